rgbw_fader: RTL and testbench
=============================

Name: rgbw_fader

Overview:
Per-channel duty slew limiter between colorGen and pwmGen. It takes the four target duties produced by colorGen and ramps the duties it presents to pwmGen toward those targets by 1 LSB per step. Steps occur at a programmable rate, qualified by the shared clk_half enable. This removes visible jumps when mode, colour or intensity changes over SPI.

Parameters:
CH_W, 8, duty width per channel
RATE_W, 8, width of fade_rate (clk_half pulses per step)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
clk_half  in  1  clock-enable strobe from clockDividerPwm; prescaler advances only when high
target_vld  in  1  one-cycle strobe: capture target_* and fade_rate
target_r  in  CH_W  red target duty
target_g  in  CH_W  green target duty
target_b  in  CH_W  blue target duty
target_w  in  CH_W  white target duty
fade_rate  in  RATE_W  clk_half pulses per 1-LSB step; 0 = immediate load
duty_r  out  CH_W  current red duty to pwmGen
duty_g  out  CH_W  current green duty to pwmGen
duty_b  out  CH_W  current blue duty to pwmGen
duty_w  out  CH_W  current white duty to pwmGen
busy  out  1  high while any duty differs from its latched target
done  out  1  one-cycle pulse when all duties reach their targets

Behaviour:
- One clock domain (clk), synchronous active-high reset.
- Reset values: duty_* = 0, internal targets = 0, rate_q = 0, prescaler = 0, state = IDLE, busy = 0, done = 0. Reset applied mid-fade aborts the fade immediately.
- Capture: target_vld high at cycle N registers tgt_* and rate_q at edge N+1. Prescaler clears to 0 at that edge. target_vld is accepted in any state.
- States are IDLE and FADE. busy = (state == FADE).
- IDLE + target_vld, rate = 0:
  - duty_* <= target_* at N+1.
  - done = 1 at N+1.
  - Stay in IDLE; busy never rises.
- IDLE + target_vld, rate > 0, all targets equal current duties: done = 1 at N+1; stay in IDLE.
- IDLE + target_vld, rate > 0, any target differs: enter FADE at N+1, so busy = 1 from N+1.
- FADE, prescaler:
  - Increments on each cycle with clk_half = 1.
  - When clk_half = 1 and prescaler == rate_q - 1, a step fires and the prescaler wraps to 0.
  - A step therefore fires every rate_q clk_half pulses. The first step fires after rate_q pulses from capture.
- Step rule, applied to all channels in parallel on the step cycle:
  - duty < tgt: duty + 1
  - duty > tgt: duty - 1
  - equal: hold
  - No overflow or underflow is possible, since duty never passes its target.
- Completion: when, after a step, every duty equals its target:
  - FADE -> IDLE on the same edge.
  - done = 1 for the following cycle; busy = 0 in that cycle.
- Retarget in FADE (target_vld during a fade):
  - New targets are latched and the prescaler restarts.
  - The ramp continues from the current duty values; there is no jump and no done pulse for the aborted fade.
  - With new rate 0: immediate load, done pulse, go to IDLE.
- target_vld and a step on the same cycle: target_vld wins and the step is discarded.
- clk_half stuck at 0 in FADE: the fade stalls; duties hold and busy stays high.
- Max fade time = 255 × rate_q clk_half pulses (rate_q = 255 gives the slowest 0 -> 255 ramp).

Decomposition:
- Shared package rgbw_pkg: CH_W, RATE_W, NUM_CH = 4, state enum {IDLE, FADE}.
- Sub-module rgbw_fade_channel, instantiated 4×:
  - Holds tgt register and duty register.
  - Inputs: load, step, immediate.
  - Outputs: duty and the at_target flag.
- Top of rgbw_fader holds the prescaler and FSM, and ANDs the 4 at_target flags.

Test Plan:
1. Reset, then idle 20 cycles -> all duty_* = 0, busy = 0, done never pulses.
2. target_vld with R = 0x40, G = 0x00, B = 0x10, W = 0xFF, rate = 0 -> next cycle duties equal targets, done = 1 for exactly one cycle, busy stays 0.
3. From all-0: target R = 3, rate = 2, clk_half every 2nd clk -> R steps to 1, 2, 3, with each step 4 clk apart; busy = 1 throughout; done pulses once after R = 3; G/B/W stay 0.
4. Fade R 0 -> 200 at rate = 1, clk_half = 1 constantly; retarget to R = 50 when R = 100 -> R ramps down 99 ... 50 with no jump; exactly one done pulse, after R = 50.
5. target_vld on the exact cycle a step would fire -> no step that cycle; new targets latched; prescaler restarts; next step comes rate_q pulses later.
6. Reset asserted mid-fade (R = 0x80 heading to 0xFF) -> next cycle all duties 0, busy 0, done 0; a new target_vld after reset works normally.

Source files
------------

// File: rtl/rgbw_pkg.sv
// Shared parameters and state type for the RGBW duty fader.
package rgbw_pkg;
    localparam int CH_W   = 8;
    localparam int RATE_W = 8;
    localparam int NUM_CH = 4;

    typedef enum logic {
        IDLE = 1'b0,
        FADE = 1'b1
    } state_t;
endpackage

// File: rtl/rgbw_fader_if.sv
// Target/duty bundle between colour generation, the fader and the PWM stage.
interface rgbw_fader_if;
    import rgbw_pkg::*;

    logic              target_vld;
    logic [CH_W-1:0]   target_r;
    logic [CH_W-1:0]   target_g;
    logic [CH_W-1:0]   target_b;
    logic [CH_W-1:0]   target_w;
    logic [RATE_W-1:0] fade_rate;
    logic [CH_W-1:0]   duty_r;
    logic [CH_W-1:0]   duty_g;
    logic [CH_W-1:0]   duty_b;
    logic [CH_W-1:0]   duty_w;
    logic              busy;
    logic              done;

    modport master (
        output target_vld, target_r, target_g, target_b, target_w, fade_rate,
        input  duty_r, duty_g, duty_b, duty_w, busy, done
    );

    modport slave (
        input  target_vld, target_r, target_g, target_b, target_w, fade_rate,
        output duty_r, duty_g, duty_b, duty_w, busy, done
    );
endinterface

// File: rtl/rgbw_fade_channel.sv
// One colour channel: latched target plus a duty that walks 1 LSB per step toward it.
module rgbw_fade_channel
    import rgbw_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic            immediate,
    input  logic            step,
    input  logic [CH_W-1:0] target,
    output logic [CH_W-1:0] duty,
    output logic            at_target,
    output logic            one_off
);
    logic [CH_W-1:0] tgt_q;
    logic [CH_W-1:0] duty_q;
    logic [CH_W:0]   duty_x;
    logic [CH_W:0]   tgt_x;

    always_ff @(posedge clk) begin
        if (reset) begin
            tgt_q  <= '0;
            duty_q <= '0;
        end else if (load) begin
            tgt_q <= target;
            if (immediate) begin
                duty_q <= target;
            end
        end else if (step) begin
            if (duty_q < tgt_q) begin
                duty_q <= duty_q + CH_W'(1);
            end else if (duty_q > tgt_q) begin
                duty_q <= duty_q - CH_W'(1);
            end
        end
    end

    // Widened compare so 255 vs 0 is not mistaken for a 1-LSB gap.
    assign duty_x    = {1'b0, duty_q};
    assign tgt_x     = {1'b0, tgt_q};
    assign one_off   = (duty_x + (CH_W+1)'(1) == tgt_x) || (tgt_x + (CH_W+1)'(1) == duty_x);
    assign at_target = (duty_q == tgt_q);
    assign duty      = duty_q;
endmodule

// File: rtl/rgbw_fader.sv
// Slew limiter ramping four PWM duties toward their targets at a clk_half-based rate.
//   state | meaning
//   IDLE  | duties equal latched targets, nothing to do
//   FADE  | at least one duty still walking toward its target
module rgbw_fader
    import rgbw_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         clk_half,
    rgbw_fader_if.slave  bus
);
    state_t            state_q, state_d;
    logic              done_q, done_d;
    logic [RATE_W-1:0] rate_q;
    logic [RATE_W-1:0] presc_q;
    logic              presc_hit;
    logic              step;
    logic              immediate;

    logic [CH_W-1:0]   tgt_in  [NUM_CH];
    logic [CH_W-1:0]   duty    [NUM_CH];
    logic [NUM_CH-1:0] at_tgt;
    logic [NUM_CH-1:0] one_off;
    logic [NUM_CH-1:0] same_tgt;

    assign tgt_in[0] = bus.target_r;
    assign tgt_in[1] = bus.target_g;
    assign tgt_in[2] = bus.target_b;
    assign tgt_in[3] = bus.target_w;

    assign immediate = bus.target_vld && (bus.fade_rate == '0);
    assign presc_hit = clk_half && (presc_q == rate_q - RATE_W'(1));
    // A capture on the step cycle wins; the step is dropped.
    assign step      = (state_q == FADE) && presc_hit && !bus.target_vld;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        rgbw_fade_channel u_ch (
            .clk       (clk),
            .reset     (reset),
            .load      (bus.target_vld),
            .immediate (immediate),
            .step      (step),
            .target    (tgt_in[i]),
            .duty      (duty[i]),
            .at_target (at_tgt[i]),
            .one_off   (one_off[i])
        );
        assign same_tgt[i] = (tgt_in[i] == duty[i]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rate_q  <= '0;
            presc_q <= '0;
        end else if (bus.target_vld) begin
            rate_q  <= bus.fade_rate;
            presc_q <= '0;
        end else if ((state_q == FADE) && clk_half) begin
            presc_q <= presc_hit ? '0 : presc_q + RATE_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        if (bus.target_vld) begin
            if (immediate || (&same_tgt)) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end else begin
                state_d = FADE;
            end
        end else if (step && (&(at_tgt | one_off))) begin
            state_d = IDLE;
            done_d  = 1'b1;
        end
    end

    assign bus.duty_r = duty[0];
    assign bus.duty_g = duty[1];
    assign bus.duty_b = duty[2];
    assign bus.duty_w = duty[3];
    assign bus.busy   = (state_q == FADE);
    assign bus.done   = done_q;
endmodule

// File: tb/tb_rgbw_fader.sv
// Self-checking bench for rgbw_fader: directed scenarios plus random traffic against a behavioural model.
module tb_rgbw_fader;
    import rgbw_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic clk_half;

    rgbw_fader_if bus();

    rgbw_fader dut (
        .clk      (clk),
        .reset    (reset),
        .clk_half (clk_half),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] m_tgt  [4];
    logic [7:0] m_duty [4];
    int         m_rate;
    int         m_pulses;
    bit         m_done;
    int         done_cnt;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit m_busy();
        bit b = 0;
        for (int c = 0; c < 4; c++) if (m_duty[c] != m_tgt[c]) b = 1;
        return b;
    endfunction

    // Model: capture resets pulse count; a step happens every m_rate clk_half pulses while any duty differs.
    task automatic model_edge(input bit rst, input bit vld, input bit half,
                              input logic [7:0] r, g, b, w, input logic [7:0] rate);
        bit ev;
        if (rst) begin
            for (int c = 0; c < 4; c++) begin m_tgt[c] = 0; m_duty[c] = 0; end
            m_rate = 0; m_pulses = 0; m_done = 0;
            return;
        end
        ev = 0;
        if (vld) begin
            m_tgt[0] = r; m_tgt[1] = g; m_tgt[2] = b; m_tgt[3] = w;
            m_rate = rate; m_pulses = 0; ev = 1;
            if (rate == 0) for (int c = 0; c < 4; c++) m_duty[c] = m_tgt[c];
        end else if (m_busy() && half) begin
            m_pulses++;
            if (m_pulses % m_rate == 0) begin
                ev = 1;
                for (int c = 0; c < 4; c++) begin
                    if (m_duty[c] < m_tgt[c]) m_duty[c] = m_duty[c] + 8'd1;
                    else if (m_duty[c] > m_tgt[c]) m_duty[c] = m_duty[c] - 8'd1;
                end
            end
        end
        m_done = ev && !m_busy();
    endtask

    task automatic cycle(input bit rst, input bit vld, input bit half,
                         input logic [7:0] r, g, b, w, input logic [7:0] rate);
        reset = rst; bus.target_vld = vld; clk_half = half;
        bus.target_r = r; bus.target_g = g; bus.target_b = b; bus.target_w = w;
        bus.fade_rate = rate;
        @(posedge clk);
        model_edge(rst, vld, half, r, g, b, w, rate);
        #1;
        check_val("duties", {bus.duty_r, bus.duty_g, bus.duty_b, bus.duty_w},
                  {m_duty[0], m_duty[1], m_duty[2], m_duty[3]});
        check_val("busy", 32'(bus.busy), 32'(m_busy()));
        check_val("done", 32'(bus.done), 32'(m_done));
        if (bus.done) done_cnt++;
        reset = 1'b0; bus.target_vld = 1'b0;
    endtask

    task automatic idle(input bit half);
        cycle(0, 0, half, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0);
    endtask

    initial begin
        int  prev, maxjump, n;
        bit  found;
        reset = 1'b1; clk_half = 1'b0; bus.target_vld = 1'b0;
        bus.target_r = '0; bus.target_g = '0; bus.target_b = '0; bus.target_w = '0;
        bus.fade_rate = '0;
        done_cnt = 0;

        // 1: reset then idle
        for (int i = 0; i < 3; i++) cycle(1, 0, 0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0);
        for (int i = 0; i < 20; i++) idle(1'($urandom_range(0, 1)));
        check_val("t1_no_done", 32'(done_cnt), 32'd0);

        // 2: immediate load
        cycle(0, 1, 0, 8'h40, 8'h00, 8'h10, 8'hFF, 8'd0);
        check_val("t2_duty_r", 32'(bus.duty_r), 32'h40);
        check_val("t2_duty_w", 32'(bus.duty_w), 32'hFF);
        check_val("t2_done", 32'(bus.done), 32'd1);
        idle(0);
        check_val("t2_done_drop", 32'(bus.done), 32'd0);

        // 3: slow ramp to 3 with clk_half every 2nd clock
        cycle(0, 1, 0, 8'h0, 8'h0, 8'h0, 8'h0, 8'd0);
        cycle(0, 1, 0, 8'd3, 8'h0, 8'h0, 8'h0, 8'd2);
        check_val("t3_busy", 32'(bus.busy), 32'd1);
        done_cnt = 0;
        for (int i = 0; i < 20; i++) idle(1'(i % 2));
        check_val("t3_final_r", 32'(bus.duty_r), 32'd3);
        check_val("t3_done_once", 32'(done_cnt), 32'd1);

        // 4: retarget mid-ramp
        cycle(0, 1, 0, 8'h0, 8'h0, 8'h0, 8'h0, 8'd0);
        cycle(0, 1, 1, 8'd200, 8'h0, 8'h0, 8'h0, 8'd1);
        found = 0;
        for (int i = 0; i < 300 && !found; i++) begin
            idle(1);
            if (bus.duty_r == 8'd100) found = 1;
        end
        check_val("t4_reach_100", 32'(found), 32'd1);
        done_cnt = 0; maxjump = 0; prev = bus.duty_r;
        cycle(0, 1, 1, 8'd50, 8'h0, 8'h0, 8'h0, 8'd1);
        for (int i = 0; i < 80; i++) begin
            n = bus.duty_r;
            if ((n > prev ? n - prev : prev - n) > maxjump) maxjump = (n > prev ? n - prev : prev - n);
            prev = n;
            idle(1);
        end
        check_val("t4_no_jump", 32'(maxjump <= 1), 32'd1);
        check_val("t4_final_r", 32'(bus.duty_r), 32'd50);
        check_val("t4_done_once", 32'(done_cnt), 32'd1);

        // 5: capture on the step cycle discards the step
        cycle(0, 1, 0, 8'h0, 8'h0, 8'h0, 8'h0, 8'd0);
        cycle(0, 1, 1, 8'd10, 8'h0, 8'h0, 8'h0, 8'd3);
        idle(1); idle(1);
        cycle(0, 1, 1, 8'd20, 8'h0, 8'h0, 8'h0, 8'd3);
        check_val("t5_no_step", 32'(bus.duty_r), 32'd0);
        idle(1); idle(1);
        check_val("t5_still0", 32'(bus.duty_r), 32'd0);
        idle(1);
        check_val("t5_step", 32'(bus.duty_r), 32'd1);

        // 6: reset mid-fade
        cycle(0, 1, 0, 8'h0, 8'h0, 8'h0, 8'h0, 8'd0);
        cycle(0, 1, 1, 8'hFF, 8'h0, 8'h0, 8'h0, 8'd1);
        found = 0;
        for (int i = 0; i < 300 && !found; i++) begin
            idle(1);
            if (bus.duty_r == 8'h80) found = 1;
        end
        check_val("t6_reach_80", 32'(found), 32'd1);
        cycle(1, 0, 1, 8'h0, 8'h0, 8'h0, 8'h0, 8'd0);
        check_val("t6_duty_r", 32'(bus.duty_r), 32'd0);
        check_val("t6_busy", 32'(bus.busy), 32'd0);
        cycle(0, 1, 1, 8'd5, 8'd6, 8'h0, 8'h0, 8'd0);
        check_val("t6_reload", 32'(bus.duty_g), 32'd6);

        // 7: random traffic
        for (int i = 0; i < 4000; i++) begin
            bit       rst = ($urandom_range(0, 599) == 0);
            bit       vld = ($urandom_range(0, 24) == 0);
            bit       hf  = 1'($urandom_range(0, 2) != 0);
            logic [7:0] base = 8'($urandom);
            cycle(rst, vld, hf,
                  base + 8'($urandom_range(0, 6)), base - 8'($urandom_range(0, 6)),
                  8'($urandom), ($urandom_range(0, 3) == 0) ? base : 8'($urandom),
                  8'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
